des_block_packer: RTL
=====================

// Module: des_block_packer
// PURPOSE
//  Byte <-> 64-bit block buffer between the I2C slave byte interface and the DES core.
//  Packs 8 received bytes into one 64-bit block and offers it with a valid/ready handshake.
//  The handshake feeds the DES io-select stage's external input when it selects external data.
//  Captures the 64-bit DES result and unpacks it into 8 bytes for I2C transmit, MSB byte first.
// PARAMETERS
//  NBYTES     8      bytes per block; fixed at 8 (64-bit DES block); other values unsupported
//  IDLE_BYTE  8'hFF  value driven on tx_byte when the transmit buffer is empty (I2C idle-high)
// PORTS
//  clk            in   1   system clock, rising edge
//  n_rst          in   1   asynchronous active-low reset
//  rx_byte        in   8   byte received by I2C slave
//  rx_byte_valid  in   1   one-cycle strobe, rx_byte valid
//  abort          in   1   I2C START/STOP mid-block: discard partial input block, clear overrun
//  blk_out        out  64  assembled block; first received byte in [63:56]
//  blk_valid      out  1   blk_out holds a complete block
//  blk_ready      in   1   DES side accepts blk_out (transfer = blk_valid & blk_ready)
//  des_result     in   64  DES output block
//  des_done       in   1   one-cycle strobe, des_result valid
//  tx_byte        out  8   next byte to transmit
//  tx_byte_valid  out  1   transmit buffer non-empty
//  tx_byte_req    in   1   one-cycle strobe, I2C consumed tx_byte
//  overrun        out  1   sticky: rx byte dropped or unread tx data overwritten
// BEHAVIOUR
//  Reset: blk_out=0, blk_valid=0, tx shift reg=0, tx_cnt=0, tx_byte=IDLE_BYTE,
//   tx_byte_valid=0, overrun=0, packer state=PK_FILL, rx_cnt=0. All outputs registered.
//  Packer FSM (rx_cnt 0..7):
//   PK_FILL: on rx_byte_valid, write byte into slot rx_cnt (slot 0 = [63:56]); rx_cnt++.
//    Byte 8 accepted at edge N -> PK_HOLD, blk_valid=1 from cycle N+1; rx_cnt wraps to 0.
//   PK_HOLD: blk_valid=1 and blk_out stable until blk_valid&blk_ready.
//    On transfer -> PK_FILL, blk_valid=0 next cycle.
//    rx_byte_valid with the transfer in the same cycle: byte accepted as slot 0 of the next block.
//    rx_byte_valid in PK_HOLD without blk_ready: byte dropped, overrun<=1.
//   abort (any state): rx_cnt=0, state=PK_FILL, blk_valid=0, overrun<=0.
//    Abort does not touch the tx side. abort has priority over a simultaneous rx_byte_valid
//    (that byte is discarded) and over a simultaneous transfer.
//  Unpacker (tx_cnt 0..8):
//   des_done: tx_shreg<=des_result, tx_cnt<=8. If tx_cnt!=0 beforehand, overrun<=1.
//   tx_byte = tx_shreg[63:56] when tx_cnt!=0, else IDLE_BYTE. tx_byte_valid = (tx_cnt!=0).
//   tx_byte_req with tx_cnt!=0: shift left 8 (zero fill), tx_cnt--. Next byte is visible next cycle.
//   tx_byte_req when empty: ignored, no flag.
//   des_done and tx_byte_req in the same cycle: the load wins, the request is ignored,
//    and overrun<=1 if tx_cnt!=0.
//  overrun: set by either side, cleared only by abort or reset. A set and an abort in the same
//   cycle resolve to cleared.
//  Reset asserted mid-block: all state returns to reset values immediately (asynchronous).
// STRUCTURE
//  des_pkg: DES_BLOCK_W=64, BYTE_W=8, NBYTES=8,
//   typedef enum logic {PK_FILL, PK_HOLD} pk_state_t.
//  One sub-module: des_block_unpacker (tx shift reg + tx_cnt + idle mux), instanced once.
//   The packer FSM stays in the top level.
// TESTING
//  1. Reset, send bytes 01..08 with blk_ready=0
//     -> blk_out=64'h0102030405060708, blk_valid=1 one cycle after byte 8; overrun=0.
//  2. Hold full block; send byte 0xAA with blk_ready=0 -> block unchanged, overrun=1;
//     pulse abort -> overrun=0, blk_valid=0.
//  3. Full block; blk_ready=1 in the same cycle as rx byte 0x11 -> transfer occurs,
//     blk_valid=0, next block starts with [63:56]=8'h11; 7 more bytes -> blk_valid=1.
//  4. Send 3 bytes, abort, then send bytes 01..08 -> blk_out=64'h0102030405060708 (partial discarded).
//  5. des_done with 64'hDEADBEEFCAFEF00D, 8 tx_byte_req -> DE,AD,BE,EF,CA,FE,F0,0D
//     in order; then tx_byte_valid=0, tx_byte=FF; a 9th req is ignored.
//  6. des_done, 2 reqs, then des_done and tx_byte_req in the same cycle with 64'h1122..88
//     -> tx_cnt=8, tx_byte=11, overrun=1; assert n_rst mid-shift -> all outputs at reset values.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared widths, packer state type and byte-slot helper for the DES block buffer
// Contents:
//   DES_BLOCK_W  block width in bits
//   BYTE_W       byte width in bits
//   NBYTES       bytes per block (fixed at 8)
//   RX_CNT_W     width of the packer byte counter
//   pk_state_t   packer FSM state
//   put_byte()   replace one byte slot of a block (slot 0 = most significant byte)
package des_pkg;

    localparam int DES_BLOCK_W = 64;
    localparam int BYTE_W      = 8;
    localparam int NBYTES      = 8;
    localparam int RX_CNT_W    = 3;

    typedef enum logic {
        PK_FILL = 1'b0,
        PK_HOLD = 1'b1
    } pk_state_t;

    function automatic logic [DES_BLOCK_W-1:0] put_byte(
        input logic [DES_BLOCK_W-1:0] blk,
        input logic [RX_CNT_W-1:0]    slot,
        input logic [BYTE_W-1:0]      b
    );
        logic [DES_BLOCK_W-1:0] r;
        r = blk;
        for (int i = 0; i < NBYTES; i++) begin
            if (slot == RX_CNT_W'(i)) begin
                r[(NBYTES-1-i)*BYTE_W +: BYTE_W] = b;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/des_block_packer_if.sv
// rtl/des_block_packer_if.sv - byte/block bus between I2C slave, DES core and the block buffer
// Signals:
//   rx_byte, rx_byte_valid   byte received from I2C slave (one-cycle strobe)
//   abort                    I2C START/STOP mid-block
//   blk_out, blk_valid       assembled 64-bit block offered to the DES side
//   blk_ready                DES side accepts blk_out
//   des_result, des_done     DES output block (one-cycle strobe)
//   tx_byte, tx_byte_valid   next byte to transmit
//   tx_byte_req              I2C consumed tx_byte (one-cycle strobe)
//   overrun                  sticky loss indication
// Modports: slave = block buffer side, master = I2C/DES environment side.
interface des_block_packer_if;
    import des_pkg::*;

    logic [BYTE_W-1:0]      rx_byte;
    logic                   rx_byte_valid;
    logic                   abort;
    logic [DES_BLOCK_W-1:0] blk_out;
    logic                   blk_valid;
    logic                   blk_ready;
    logic [DES_BLOCK_W-1:0] des_result;
    logic                   des_done;
    logic [BYTE_W-1:0]      tx_byte;
    logic                   tx_byte_valid;
    logic                   tx_byte_req;
    logic                   overrun;

    modport slave (
        input  rx_byte, rx_byte_valid, abort, blk_ready, des_result, des_done, tx_byte_req,
        output blk_out, blk_valid, tx_byte, tx_byte_valid, overrun
    );

    modport master (
        output rx_byte, rx_byte_valid, abort, blk_ready, des_result, des_done, tx_byte_req,
        input  blk_out, blk_valid, tx_byte, tx_byte_valid, overrun
    );

endinterface

// File: rtl/des_block_unpacker.sv
// rtl/des_block_unpacker.sv - 64-bit DES result to MSB-first byte stream for I2C transmit
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset
//   des_result      DES output block
//   des_done        one-cycle strobe, des_result valid
//   tx_byte_req     one-cycle strobe, current tx_byte consumed
//   tx_byte         registered next byte, IDLE_BYTE when empty
//   tx_byte_valid   registered, buffer non-empty
//   tx_overwrite    combinational pulse: a load is replacing unread bytes
module des_block_unpacker
    import des_pkg::*;
#(
    parameter logic [BYTE_W-1:0] IDLE_BYTE = 8'hFF
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [DES_BLOCK_W-1:0] des_result,
    input  logic                   des_done,
    input  logic                   tx_byte_req,
    output logic [BYTE_W-1:0]      tx_byte,
    output logic                   tx_byte_valid,
    output logic                   tx_overwrite
);

    logic [DES_BLOCK_W-1:0] tx_shreg;
    logic [DES_BLOCK_W-1:0] nxt_shreg;
    logic [3:0]             tx_cnt;
    logic [3:0]             nxt_cnt;

    assign tx_overwrite = des_done && (tx_cnt != 4'd0);

    // A load takes priority over a same-cycle request; the request is simply lost.
    always_comb begin
        nxt_shreg = tx_shreg;
        nxt_cnt   = tx_cnt;
        if (des_done) begin
            nxt_shreg = des_result;
            nxt_cnt   = 4'(NBYTES);
        end else if (tx_byte_req && (tx_cnt != 4'd0)) begin
            nxt_shreg = {tx_shreg[DES_BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            nxt_cnt   = tx_cnt - 4'd1;
        end
    end

    // tx_byte/tx_byte_valid are registered from the next-state values so the
    // outputs change on the same edge as the shift register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_shreg      <= '0;
            tx_cnt        <= 4'd0;
            tx_byte       <= IDLE_BYTE;
            tx_byte_valid <= 1'b0;
        end else begin
            tx_shreg      <= nxt_shreg;
            tx_cnt        <= nxt_cnt;
            tx_byte       <= (nxt_cnt != 4'd0) ? nxt_shreg[DES_BLOCK_W-1 -: BYTE_W] : IDLE_BYTE;
            tx_byte_valid <= (nxt_cnt != 4'd0);
        end
    end

endmodule

// File: rtl/des_block_packer.sv
// rtl/des_block_packer.sv - byte <-> 64-bit block buffer between I2C slave and DES core
// Ports:
//   clk     system clock, rising edge
//   n_rst   asynchronous active-low reset
//   bus     des_block_packer_if.slave: rx byte in, block out with valid/ready,
//           DES result in, tx byte out, abort, sticky overrun
// Parameters:
//   IDLE_BYTE  value on tx_byte while the transmit buffer is empty
module des_block_packer
    import des_pkg::*;
#(
    parameter logic [BYTE_W-1:0] IDLE_BYTE = 8'hFF
) (
    input  logic                clk,
    input  logic                n_rst,
    des_block_packer_if.slave   bus
);

    localparam logic [RX_CNT_W-1:0] LAST_SLOT = RX_CNT_W'(NBYTES - 1);

    pk_state_t              state;
    logic [RX_CNT_W-1:0]    rx_cnt;
    logic [DES_BLOCK_W-1:0] blk_out_q;
    logic                   blk_valid_q;
    logic                   overrun_q;
    logic                   drop;
    logic                   tx_overwrite;

    // A byte arriving while a full block is still waiting has nowhere to go.
    assign drop = (state == PK_HOLD) && bus.rx_byte_valid && !bus.blk_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= PK_FILL;
            rx_cnt      <= '0;
            blk_out_q   <= '0;
            blk_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (bus.abort) begin
            // Abort wins over any same-cycle byte, transfer or overrun set.
            state       <= PK_FILL;
            rx_cnt      <= '0;
            blk_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (drop || tx_overwrite) begin
                overrun_q <= 1'b1;
            end
            case (state)
                PK_FILL: begin
                    if (bus.rx_byte_valid) begin
                        blk_out_q <= put_byte(blk_out_q, rx_cnt, bus.rx_byte);
                        if (rx_cnt == LAST_SLOT) begin
                            state       <= PK_HOLD;
                            blk_valid_q <= 1'b1;
                            rx_cnt      <= '0;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                end
                PK_HOLD: begin
                    if (bus.blk_ready) begin
                        state       <= PK_FILL;
                        blk_valid_q <= 1'b0;
                        // A byte coincident with the transfer starts the next block.
                        if (bus.rx_byte_valid) begin
                            blk_out_q <= put_byte(blk_out_q, '0, bus.rx_byte);
                            rx_cnt    <= RX_CNT_W'(1);
                        end
                    end
                end
                default: state <= PK_FILL;
            endcase
        end
    end

    assign bus.blk_out   = blk_out_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.overrun   = overrun_q;

    des_block_unpacker #(
        .IDLE_BYTE (IDLE_BYTE)
    ) u_unpacker (
        .clk           (clk),
        .n_rst         (n_rst),
        .des_result    (bus.des_result),
        .des_done      (bus.des_done),
        .tx_byte_req   (bus.tx_byte_req),
        .tx_byte       (bus.tx_byte),
        .tx_byte_valid (bus.tx_byte_valid),
        .tx_overwrite  (tx_overwrite)
    );

endmodule
